// File: rtl/ph_port_scheduler.sv
// Round-robin pheromone deposit scheduler with a periodic evaporation sweep.
// Optional build macro PH_SAT_EN: deposits saturate at all-ones instead of wrapping.
module ph_port_scheduler #(
  parameter int NUM_AGENTS = 8,
  parameter int ADDR_W     = 8,
  parameter int PH_W       = 16,
  parameter int MAP_SIZE   = 100,
  parameter int EV_FREQ    = 10000,
  parameter int DEPOSIT    = 1,
  parameter int BACK_PR    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_AGENTS-1:0]        req,
  input  logic [NUM_AGENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_AGENTS-1:0]        req_solved,
  output logic [NUM_AGENTS-1:0]        ack,
  output logic                         stall,
  output logic [ADDR_W-1:0]            addra,
  output logic                         wea,
  output logic [PH_W-1:0]              dina,
  input  logic [PH_W-1:0]              douta,
  output logic [ADDR_W-1:0]            addrb,
  output logic                         web,
  output logic [PH_W-1:0]              dinb,
  input  logic [PH_W-1:0]              doutb
);

  localparam int IDX_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam int CNT_W = (EV_FREQ > 1) ? $clog2(EV_FREQ) : 1;
  localparam logic [CNT_W-1:0]  EV_LAST  = CNT_W'(EV_FREQ - 1);
  localparam logic [ADDR_W-1:0] MAP_LAST = ADDR_W'(MAP_SIZE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_AGENTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_EV_RD,
    S_EV_WR
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_winner;
  logic [CNT_W-1:0]      r_evcnt;
  logic                  r_ev_pending;
  logic                  r_stall;
  logic                  r_wea;
  logic                  r_web;
  logic [ADDR_W-1:0]     r_addra;
  logic [ADDR_W-1:0]     r_addrb;
  logic [PH_W-1:0]       r_inc;
  logic [NUM_AGENTS-1:0] r_ack;

  logic [IDX_W-1:0]      w_winner;
  logic [IDX_W-1:0]      w_cand;
  logic [PH_W-1:0]       w_dep;
  logic [PH_W-1:0]       w_evap;

  // Scan from the farthest offset down so the nearest requester at/after r_ptr wins.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned i = NUM_AGENTS; i > 0; i--) begin
      w_cand = IDX_W'((32'(r_ptr) + i - 1) % NUM_AGENTS);
      if (req[w_cand]) w_winner = w_cand;
    end
  end

`ifdef PH_SAT_EN
  logic [PH_W:0] w_sum;
  assign w_sum = {1'b0, doutb} + {1'b0, r_inc};
  assign w_dep = w_sum[PH_W] ? '1 : w_sum[PH_W-1:0];
`else
  assign w_dep = doutb + r_inc;
`endif

  assign w_evap = douta - (douta >> 2);

  // Write data depends on read data arriving in the write cycle itself.
  assign dina  = r_wea ? w_evap : '0;
  assign dinb  = r_web ? w_dep : '0;
  assign wea   = r_wea;
  assign web   = r_web;
  assign addra = r_addra;
  assign addrb = r_addrb;
  assign ack   = r_ack;
  assign stall = r_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_winner     <= '0;
      r_evcnt      <= '0;
      r_ev_pending <= 1'b0;
      r_stall      <= 1'b0;
      r_wea        <= 1'b0;
      r_web        <= 1'b0;
      r_addra      <= '0;
      r_addrb      <= '0;
      r_inc        <= '0;
      r_ack        <= '0;
    end else begin
      r_evcnt <= (r_evcnt == EV_LAST) ? '0 : r_evcnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_ev_pending) begin
            r_addra <= '0;
            r_stall <= 1'b1;
            r_state <= S_EV_RD;
          end else if (|req) begin
            r_winner <= w_winner;
            r_addrb  <= req_addr[w_winner*ADDR_W +: ADDR_W];
            r_inc    <= req_solved[w_winner] ? PH_W'(BACK_PR) : PH_W'(DEPOSIT);
            r_state  <= S_RD;
          end
        end
        S_RD: begin
          r_web   <= 1'b1;
          r_ack   <= NUM_AGENTS'(1) << r_winner;
          r_state <= S_WR;
        end
        S_WR: begin
          r_web   <= 1'b0;
          r_ack   <= '0;
          r_ptr   <= (r_winner == IDX_LAST) ? '0 : r_winner + 1'b1;
          r_state <= S_IDLE;
        end
        S_EV_RD: begin
          r_wea   <= 1'b1;
          r_state <= S_EV_WR;
        end
        S_EV_WR: begin
          r_wea <= 1'b0;
          if (r_addra == MAP_LAST) begin
            r_ev_pending <= 1'b0;
            r_stall      <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_addra <= r_addra + 1'b1;
            r_state <= S_EV_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A new period boundary outranks the end-of-sweep clear above.
      if (r_evcnt == EV_LAST) r_ev_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ph_port_scheduler.sv
// Self-checking bench for ph_port_scheduler: directed cases plus random traffic
// against a cell-level pheromone model; honours PH_SAT_EN like the design.
module tb_ph_port_scheduler;

  localparam int NA  = 8;
  localparam int AW  = 8;
  localparam int PW  = 16;
  localparam int MS  = 100;
  localparam int EVF = 500;
`ifdef PH_SAT_EN
  localparam logic [PW-1:0] SAT_EXP = 16'hFFFF;
`else
  localparam logic [PW-1:0] SAT_EXP = 16'h0001;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NA-1:0]    req, req_solved, ack;
  logic [NA*AW-1:0] req_addr;
  logic             stall, wea, web;
  logic [AW-1:0]    addra, addrb;
  logic [PW-1:0]    dina, douta, dinb, doutb;
  logic [AW-1:0]    a_addr [NA];

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < NA; i++) req_addr[i*AW +: AW] = a_addr[i];
  end

  ph_port_scheduler #(
    .NUM_AGENTS(NA), .ADDR_W(AW), .PH_W(PW), .MAP_SIZE(MS),
    .EV_FREQ(EVF), .DEPOSIT(1), .BACK_PR(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_solved(req_solved),
    .ack(ack), .stall(stall),
    .addra(addra), .wea(wea), .dina(dina), .douta(douta),
    .addrb(addrb), .web(web), .dinb(dinb), .doutb(doutb)
  );

  // Dual-port RAM, one-cycle read latency, bulk-loadable from img.
  logic [PW-1:0] mem [256];
  logic [PW-1:0] img [256];
  logic          fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else begin
      if (wea) mem[addra] <= dina;
      if (web) mem[addrb] <= dinb;
    end
    douta <= mem[addra];
    doutb <= mem[addrb];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req  = '0;
    fill = 1'b1;
    @(posedge clk);
    #1 fill = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Reference model state for the random phase
  logic [PW-1:0] ref_mem [256];
  bit            pend [NA];
  int            mptr, n_acks, st_len;
  logic [NA-1:0] h0, h1;
  bit            prev_stall;

  task automatic step(input bit gen);
    int w, a, s;
    @(negedge clk);
    if (stall && !prev_stall) begin
      for (int i = 0; i < MS; i++) ref_mem[i] = ref_mem[i] - (ref_mem[i] >> 2);
      st_len = 0;
    end
    if (stall) st_len++;
    if (!stall && prev_stall) chk("rand_sweep_len", st_len, 2*MS);
    prev_stall = stall;
    if (wea || web) chk("rand_port_excl", {31'b0, wea && web}, 0);
    if (ack != '0) begin
      chk("rand_ack_in_stall", {31'b0, stall}, 0);
      w = -1;
      for (int k = NA - 1; k >= 0; k--)
        if (h1[(mptr + k) % NA]) w = (mptr + k) % NA;
      chk("rand_ack_grant", {24'b0, ack}, (w < 0) ? 32'd0 : (32'd1 << w));
      if (w >= 0) begin
        a = int'(a_addr[w]);
        s = int'(ref_mem[a]) + (req_solved[w] ? 3 : 1);
`ifdef PH_SAT_EN
        if (s > 65535) s = 65535;
`endif
        ref_mem[a] = PW'(s);
        pend[w] = 0;
        req[w] = 1'b0;
        mptr = (w + 1) % NA;
        n_acks++;
      end
    end
    if (gen) begin
      for (int i = 0; i < NA; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1;
          req[i] = 1'b1;
          a_addr[i] = AW'($urandom_range(255));
          req_solved[i] = $urandom_range(1) == 1;
        end
      end
    end
    h1 = h0;
    h0 = req;
  endtask

  initial begin
    int cnt, last, c_ack, c_st, st, nw;
    bit found;
    rst = 1'b0; req = '0; req_solved = '0; fill = 1'b0;
    for (int i = 0; i < NA; i++) a_addr[i] = '0;
    for (int i = 0; i < 256; i++) img[i] = 16'd100;
    img[37] = 16'd5;
    img[60] = 16'hFFFE;

    // Reset values, then a single explore deposit and a saturating/wrapping one
    do_reset();
    @(negedge clk);
    chk("rst_ack", {24'b0, ack}, 0);   chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_wea", {31'b0, wea}, 0);   chk("rst_web", {31'b0, web}, 0);
    chk("rst_addra", {24'b0, addra}, 0); chk("rst_addrb", {24'b0, addrb}, 0);
    chk("rst_dina", {16'b0, dina}, 0); chk("rst_dinb", {16'b0, dinb}, 0);
    req[2] = 1'b1; a_addr[2] = 8'd37; req_solved[2] = 1'b0;
    @(negedge clk);
    chk("a_addrb", {24'b0, addrb}, 37); chk("a_web_rd", {31'b0, web}, 0);
    chk("a_ack_rd", {24'b0, ack}, 0);
    @(negedge clk);
    chk("a_web", {31'b0, web}, 1); chk("a_dinb", {16'b0, dinb}, 6);
    chk("a_ack", {24'b0, ack}, 32'h04);
    req[2] = 1'b0;
    @(negedge clk);
    chk("a_ack_pulse", {24'b0, ack}, 0); chk("a_web_off", {31'b0, web}, 0);
    req[5] = 1'b1; a_addr[5] = 8'd60; req_solved[5] = 1'b1;
    @(negedge clk);
    chk("b_addrb", {24'b0, addrb}, 60);
    @(negedge clk);
    chk("b_dinb", {16'b0, dinb}, {16'b0, SAT_EXP}); chk("b_ack", {24'b0, ack}, 32'h20);
    req[5] = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_mem37", {16'b0, mem[37]}, 6); chk("b_mem60", {16'b0, mem[60]}, {16'b0, SAT_EXP});

    // Everyone requesting from pointer 0: strict rotation, one grant per 3 cycles
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NA; i++) a_addr[i] = AW'(200 + i);
    req_solved = '0;
    req = '1;
    cnt = 0; last = 0;
    for (int c = 0; c < 60 && cnt < 9; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("rr_order", {24'b0, ack}, 32'd1 << (cnt % NA));
        if (cnt > 0) chk("rr_spacing", c - last, 3);
        last = c;
        cnt++;
        if (cnt == 9) req = '0;
      end
    end
    chk("rr_count", cnt, 9);
    repeat (3) @(negedge clk);

    // Period boundary lands while a deposit is in RD: deposit finishes, then sweep
    for (int i = 0; i < 256; i++) img[i] = 16'd100;
    do_reset();
    @(negedge clk);
    repeat (EVF - 2) @(negedge clk);
    req[1] = 1'b1; a_addr[1] = 8'd150; req_solved[1] = 1'b0;
    c_ack = -1; c_st = -1; st = 0; nw = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("ev_ack_nostall", {31'b0, stall}, 0);
        chk("ev_dep_data", {16'b0, dinb}, 101);
        c_ack = c;
        req = '0;
      end
      if (stall) begin
        if (c_st < 0) c_st = c;
        st++;
      end
      if (wea) begin
        chk("ev_addr", {24'b0, addra}, nw);
        chk("ev_dina", {16'b0, dina}, 75);
        chk("ev_no_web", {31'b0, web}, 0);
        nw++;
      end
      if (c_st >= 0 && !stall) break;
    end
    chk("ev_after_wr", c_st - c_ack, 2);
    chk("ev_stall_len", st, 2*MS);
    chk("ev_wea_cnt", nw, MS);

    // Reset in the middle of a sweep; the period counter must restart from zero
    do_reset();
    found = 0;
    for (int c = 0; c < EVF + 10 && !found; c++) begin
      @(negedge clk);
      found = stall;
    end
    chk("e_sweep_start", {31'b0, found}, 1);
    found = 0;
    for (int c = 0; c < 2*MS + 10 && !found; c++) begin
      @(negedge clk);
      found = wea && (addra == 8'd50);
    end
    chk("e_reach_50", {31'b0, found}, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("e_stall", {31'b0, stall}, 0); chk("e_wea", {31'b0, wea}, 0);
    chk("e_ack", {24'b0, ack}, 0);     chk("e_addra", {24'b0, addra}, 0);
    rst = 1'b1;
    repeat (EVF) @(negedge clk);
    chk("e_cnt_before", {31'b0, stall}, 0);
    @(negedge clk);
    chk("e_cnt_restart", {31'b0, stall}, 1);

    // Random traffic against the cell-level model
    for (int i = 0; i < 256; i++) begin
      img[i] = PW'($urandom_range(65535));
      ref_mem[i] = img[i];
    end
    for (int i = 0; i < NA; i++) pend[i] = 0;
    mptr = 0; n_acks = 0; st_len = 0; h0 = '0; h1 = '0; prev_stall = 0;
    do_reset();
    repeat (3000) step(1);
    repeat (400) step(0);
    chk("rand_acks_seen", {31'b0, n_acks > 100}, 1);
    chk("rand_drained", {24'b0, req}, 0);
    for (int i = 0; i < 256; i++)
      chk($sformatf("rand_mem[%0d]", i), {16'b0, mem[i]}, {16'b0, ref_mem[i]});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ph_port_scheduler.md
PH_PORT_SCHEDULER -- requirements
Module: ph_port_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_AGENTS 8, number of requesters; ADDR_W 8, pheromone RAM address width; PH_W 16, pheromone width; MAP_SIZE 100, swept cells; EV_FREQ 10000, evaporation period in cycles; DEPOSIT 1, explore increment; BACK_PR 3, solved-path increment.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
REQ-004 req  in  NUM_AGENTS  per-agent deposit request; held high until matching ack.
REQ-005 req_addr  in  NUM_AGENTS*ADDR_W  per-agent cell address; agent i at [i*ADDR_W +: ADDR_W].
REQ-006 req_solved  in  NUM_AGENTS  1 selects BACK_PR, 0 selects DEPOSIT.
REQ-007 ack  out  NUM_AGENTS  one-hot, one-cycle pulse when agent's write is issued.
REQ-008 stall  out  1  high throughout an evaporation sweep.
REQ-009 addra/wea/dina  out  ADDR_W/1/PH_W  RAM port A (evaporation only); douta  in  PH_W.
REQ-010 addrb/web/dinb  out  ADDR_W/1/PH_W  RAM port B (deposits only); doutb  in  PH_W.

Function
REQ-011 RAM SHALL be treated as synchronous read, latency 1: address registered on edge N, data valid after edge N+1.
REQ-012 FSM states SHALL be IDLE, RD, WR, EV_RD, EV_WR.
REQ-013 IDLE: if ev_pending -> EV_RD with sweep address 0 and stall=1; else if any req -> latch winner index, addrb<=req_addr[winner], inc<=req_solved ? BACK_PR : DEPOSIT, -> RD; else stay.
REQ-014 RD: one wait cycle, web=0, -> WR.
REQ-015 WR: web=1, dinb=doutb+inc, ack[winner]=1 for this cycle only, round-robin pointer <= winner+1 (mod NUM_AGENTS), -> IDLE.
REQ-016 Arbitration SHALL be round-robin: first asserted req at or after pointer, wrapping; pointer reset value 0.
REQ-017 Deposit SHALL take exactly 3 cycles IDLE->RD->WR; a continuously requesting set is served one per 3 cycles, each agent at most once per NUM_AGENTS grants.
REQ-018 Evaporation counter SHALL be free-running 0..EV_FREQ-1, wrapping; reaching EV_FREQ-1 sets ev_pending; if already set it stays set (no double sweep).
REQ-019 ev_pending SHALL take priority over req in IDLE; an in-flight deposit SHALL complete before the sweep starts.
REQ-020 EV_RD: addra=sweep address, wea=0, -> EV_WR.
REQ-021 EV_WR: wea=1, dina=douta-(douta>>2) (3/4, floor); if sweep address==MAP_SIZE-1 -> IDLE, clear ev_pending, stall<=0; else increment address, -> EV_RD.
REQ-022 Sweep SHALL last exactly 2*MAP_SIZE cycles; no ack SHALL occur while stall=1.
REQ-023 Ports A and B SHALL never write the same cycle; wea and web SHALL be 0 outside EV_WR and WR respectively.
REQ-024 A req dropped before its ack is a protocol violation; behaviour unspecified but FSM SHALL still return to IDLE.

Reset
REQ-025 On rst==0: state IDLE, pointer 0, evaporation counter 0, ev_pending 0, sweep address 0, stall 0, ack 0, wea 0, web 0, addra/addrb/dina/dinb 0.
REQ-026 Reset mid-deposit or mid-sweep SHALL abort without write on the following cycle; no ack pulse is emitted.

Configuration
REQ-027 With PH_SAT_EN defined, dinb SHALL saturate at 2^PH_W-1 on overflow; without it, dinb SHALL wrap modulo 2^PH_W.

Verification
REQ-028 Single req[2]=1, addr 37, solved 0, doutb=5 -> addrb=37 after 1 cycle, web=1 with dinb=6 and ack[2] pulse 2 cycles after acceptance.
REQ-029 All req high, pointer 0 -> acks in order 0,1,...,7,0 at 3-cycle spacing.
REQ-030 Counter hits EV_FREQ-1 during RD -> deposit's WR completes, then stall=1 for 200 cycles, wea pulses at addra 0..99, douta=100 -> dina=75, no ack during sweep.
REQ-031 req_solved=1, doutb=0xFFFE -> dinb=0xFFFF with PH_SAT_EN, 0x0001 without.
REQ-032 rst=0 asserted in EV_WR at address 50 -> next cycle stall=0, wea=0, state IDLE; counter restarts at 0.
